// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add controller: FSM states, default width
// and the bit-counter sizing helper.
package serial_add_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must hold WIDTH-1 and is never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? int'($clog2(w)) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fulladder.sv
// Single-bit full adder shared by the serial datapath.
module serial_add_ctrl_fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum_c,
    output logic c_out_c
);

    assign sum_c   = a ^ b ^ c_in;
    assign c_out_c = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: adds two WIDTH-bit operands LSB first through one shared
// full adder, with a start/busy/done handshake and a held result for display.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_n;
    logic             start_q;
    logic [WIDTH-1:0] a_sr, a_sr_n;
    logic [WIDTH-1:0] b_sr, b_sr_n;
    logic [WIDTH-1:0] sum_sr, sum_sr_n;
    logic             carry, carry_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;
    logic             busy_n, done_n;
    logic             launch_c;
    logic             fa_sum_c, fa_cout_c;

    assign launch_c = start & ~start_q;

    serial_add_ctrl_fulladder u_fa (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .c_in   (carry),
        .sum_c  (fa_sum_c),
        .c_out_c(fa_cout_c)
    );

    // State and datapath registers; start_q resets high so a held start cannot launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= 1'b1;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= start;
            a_sr    <= a_sr_n;
            b_sr    <= b_sr_n;
            sum_sr  <= sum_sr_n;
            carry   <= carry_n;
            cnt     <= cnt_n;
            sum     <= sum_n;
            cout    <= cout_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and datapath update; busy/done are registered decodes of the next state.
    always_comb begin
        state_n  = state;
        a_sr_n   = a_sr;
        b_sr_n   = b_sr;
        sum_sr_n = sum_sr;
        carry_n  = carry;
        cnt_n    = cnt;
        sum_n    = sum;
        cout_n   = cout;

        case (state)
            ST_IDLE: begin
                if (launch_c) begin
                    a_sr_n  = a;
                    b_sr_n  = b;
                    carry_n = 1'b0;
                    cnt_n   = '0;
                    state_n = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_sr_n = (sum_sr >> 1) | (WIDTH'(fa_sum_c) << (WIDTH - 1));
                a_sr_n   = a_sr >> 1;
                b_sr_n   = b_sr >> 1;
                carry_n  = fa_cout_c;
                cnt_n    = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    sum_n   = sum_sr_n;
                    cout_n  = fa_cout_c;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n == ST_ADD);
        done_n = (state_n == ST_DONE);
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=2 and WIDTH=4.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start2, start4;
    logic [1:0] a2, b2, sum2;
    logic [3:0] a4, b4, sum4;
    logic       busy2, done2, cout2;
    logic       busy4, done4, cout4;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int a;
        int b;
        int exp_sum;
        int exp_cout;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one add on the selected instance and check handshake timing.
    task automatic op(input int w, input int av, input int bv, input bit wiggle,
                      output int res_sum, output int res_cout);
        int nbusy;
        int ndone;
        int didx;
        nbusy = 0;
        ndone = 0;
        didx  = -1;
        if (w == 2) start2 = 1'b0; else start4 = 1'b0;
        step();
        if (w == 2) begin a2 = 2'(av); b2 = 2'(bv); start2 = 1'b1; end
        else        begin a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; end
        step();
        for (int k = 0; k < w + 6; k++) begin
            if ((w == 2) ? busy2 : busy4) nbusy++;
            if ((w == 2) ? done2 : done4) begin ndone++; didx = k; end
            if (wiggle) begin
                a2 = 2'($urandom); b2 = 2'($urandom);
                a4 = 4'($urandom); b4 = 4'($urandom);
            end
            step();
        end
        if (w == 2) start2 = 1'b0; else start4 = 1'b0;
        check($sformatf("busy_cycles w%0d a%0d b%0d", w, av, bv), nbusy, w);
        check($sformatf("done_pulses w%0d a%0d b%0d", w, av, bv), ndone, 1);
        check($sformatf("done_index w%0d a%0d b%0d", w, av, bv), didx, w);
        res_sum  = (w == 2) ? int'(sum2) : int'(sum4);
        res_cout = (w == 2) ? int'(cout2) : int'(cout4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rs, rc, nb, nd, av, bv, held;

        vecs[0] = '{3, 3, 2, 1};
        vecs[1] = '{1, 2, 3, 0};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{2, 2, 0, 1};
        vecs[4] = '{3, 1, 0, 1};
        vecs[5] = '{2, 1, 3, 0};

        // Reset with start held high across release: no launch afterwards.
        rst = 1'b1; start2 = 1'b1; start4 = 1'b1;
        a2 = 2'd3; b2 = 2'd3; a4 = 4'd9; b4 = 4'd9;
        #22;
        check("reset_busy", int'(busy2), 0);
        check("reset_done", int'(done2), 0);
        check("reset_result", int'({cout2, sum2}), 0);
        check("reset_result_w4", int'({cout4, sum4}), 0);
        rst = 1'b0;
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (busy2 || done2 || busy4 || done4) nb++;
        end
        check("held_start_through_reset", nb, 0);
        start2 = 1'b0; start4 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            op(2, vecs[i].a, vecs[i].b, 1'b0, rs, rc);
            check($sformatf("vec%0d_sum", i), rs, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), rc, vecs[i].exp_cout);
        end

        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                op(2, x, y, 1'b0, rs, rc);
                check($sformatf("pair_%0d_%0d", x, y), rc * 4 + rs, x + y);
            end
        end

        // Start held high 20 cycles: one pulse, result stable afterwards.
        start2 = 1'b0; step();
        a2 = 2'd2; b2 = 2'd1; start2 = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done2) nd++;
        end
        check("held_start_pulses", nd, 1);
        check("held_start_result", int'({cout2, sum2}), 3);
        held = int'({cout2, sum2});
        start2 = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("idle_result_held", int'({cout2, sum2}), held);

        // Rising start while busy is ignored.
        step();
        a2 = 2'd1; b2 = 2'd1; start2 = 1'b1;
        step();
        nd = (done2) ? 1 : 0;
        start2 = 1'b0;
        step();
        if (done2) nd++;
        a2 = 2'd3; b2 = 2'd3; start2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done2) nd++;
        end
        check("busy_launch_pulses", nd, 1);
        check("busy_launch_sum", int'(sum2), 2);
        check("busy_launch_cout", int'(cout2), 0);
        start2 = 1'b0;

        // Reset mid-ADD clears outputs immediately; held start does not relaunch.
        step();
        a2 = 2'd3; b2 = 2'd3; start2 = 1'b1;
        step();
        check("midadd_busy_before", int'(busy2), 1);
        #2 rst = 1'b1;
        #1;
        check("midadd_rst_busy", int'(busy2), 0);
        check("midadd_rst_done", int'(done2), 0);
        check("midadd_rst_result", int'({cout2, sum2}), 0);
        step(); step();
        #2 rst = 1'b0;
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (busy2 || done2) nb++;
        end
        check("midadd_no_relaunch", nb, 0);
        check("midadd_result_stays", int'({cout2, sum2}), 0);
        start2 = 1'b0;

        // WIDTH=4 corner: full carry ripple with operands toggling during ADD.
        op(4, 15, 1, 1'b1, rs, rc);
        check("w4_15_1_sum", rs, 0);
        check("w4_15_1_cout", rc, 1);

        for (int i = 0; i < 25; i++) begin
            av = int'($urandom_range(0, 3));
            bv = int'($urandom_range(0, 3));
            op(2, av, bv, 1'b1, rs, rc);
            check($sformatf("rand_w2_%0d", i), rc * 4 + rs, av + bv);
        end
        for (int i = 0; i < 15; i++) begin
            av = int'($urandom_range(0, 15));
            bv = int'($urandom_range(0, 15));
            op(4, av, bv, 1'b1, rs, rc);
            check($sformatf("rand_w4_%0d", i), rc * 16 + rs, av + bv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
